// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle core: gates commits via cpu_en,
// takes debug commands over valid/ready, matches PC breakpoints and keeps perf counters.
module cpu_run_ctrl #(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int NUM_BP      = 2,
  parameter  int COUNT_WIDTH = 32,
  localparam int IDX_W       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [IDX_W-1:0]       cmd_idx,
  input  logic [COUNT_WIDTH-1:0] cmd_data,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic                   cpu_en,
  output logic                   halted,
  output logic [1:0]             halt_reason,
  output logic                   bp_hit,
  output logic [COUNT_WIDTH-1:0] cycle_cnt,
  output logic [COUNT_WIDTH-1:0] retired_cnt
);

  typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP, ST_RUN_N} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_RUN, OP_HALT, OP_STEP, OP_RUN_N, OP_SET_BP, OP_CLR_BP, OP_CLR_CNT
  } op_e;

  localparam logic [1:0] RSN_RESET = 2'd0;
  localparam logic [1:0] RSN_CMD   = 2'd1;
  localparam logic [1:0] RSN_BP    = 2'd2;
  localparam logic [1:0] RSN_COUNT = 2'd3;

  state_e                 state_q, state_d;
  logic [1:0]             reason_q, reason_d;
  logic                   bp_hit_q, bp_hit_d;
  logic [NUM_BP-1:0]      bp_valid_q, bp_valid_d;
  logic [ADDR_WIDTH-1:0]  bp_addr_q [NUM_BP];
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   skip_bp_q, skip_bp_d;
  logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;

  op_e  op;
  logic accept;
  logic idx_ok;
  logic bp_wr;
  logic bp_any;
  logic bp_match;

  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready;
  assign idx_ok = 32'(cmd_idx) < NUM_BP;
  assign bp_wr  = accept && (op == OP_SET_BP) && idx_ok;

  always_comb begin
    bp_any = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_valid_q[i] && (bp_addr_q[i] == pc)) bp_any = 1'b1;
    end
    bp_match = bp_any && !skip_bp_q;
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state logic lives in always_comb.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_HALT;
      reason_q    <= RSN_RESET;
      bp_hit_q    <= 1'b0;
      bp_valid_q  <= '0;
      remaining_q <= '0;
      skip_bp_q   <= 1'b0;
      cycle_q     <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      reason_q    <= reason_d;
      bp_hit_q    <= bp_hit_d;
      bp_valid_q  <= bp_valid_d;
      remaining_q <= remaining_d;
      skip_bp_q   <= skip_bp_d;
      cycle_q     <= cycle_d;
      retired_q   <= retired_d;
    end
  end

  // NOTE: breakpoint addresses are deliberately left unreset; bp_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (bp_wr) bp_addr_q[cmd_idx] <= ADDR_WIDTH'(cmd_data);
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    reason_d    = reason_q;
    remaining_d = remaining_q;
    skip_bp_d   = skip_bp_q;
    bp_hit_d    = 1'b0;
    bp_valid_d  = bp_valid_q;

    if (cpu_en) skip_bp_d = 1'b0;

    unique case (state_q)
      ST_HALT: begin
        if (accept) begin
          case (op)
            OP_RUN:  begin state_d = ST_RUN;  skip_bp_d = 1'b1; end
            OP_STEP: begin state_d = ST_STEP; skip_bp_d = 1'b1; end
            OP_RUN_N: begin
              if (cmd_data == '0) begin
                reason_d = RSN_COUNT;
              end else begin
                state_d     = ST_RUN_N;
                remaining_d = cmd_data;
                skip_bp_d   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_STEP: begin
        state_d  = ST_HALT;
        reason_d = RSN_CMD;
      end
      ST_RUN: begin
        if (bp_match) begin
          state_d  = ST_HALT;
          reason_d = RSN_BP;
          bp_hit_d = 1'b1;
        end else if (accept && op == OP_HALT) begin
          state_d  = ST_HALT;
          reason_d = RSN_CMD;
        end
      end
      ST_RUN_N: begin
        // Priority: breakpoint, then count exhausted, then HALT command.
        if (bp_match) begin
          state_d  = ST_HALT;
          reason_d = RSN_BP;
          bp_hit_d = 1'b1;
        end else begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_d  = ST_HALT;
            reason_d = RSN_COUNT;
          end else if (accept && op == OP_HALT) begin
            state_d  = ST_HALT;
            reason_d = RSN_CMD;
          end
        end
      end
    endcase

    if (accept && idx_ok) begin
      if (op == OP_SET_BP) bp_valid_d[cmd_idx] = 1'b1;
      if (op == OP_CLR_BP) bp_valid_d[cmd_idx] = 1'b0;
    end

    if (accept && op == OP_CLR_CNT) begin
      cycle_d   = '0;
      retired_d = '0;
    end else begin
      cycle_d   = cycle_q + 1'b1;
      retired_d = retired_q + COUNT_WIDTH'(cpu_en);
    end
  end

  always_comb begin
    cmd_ready = nreset && (state_q != ST_STEP);
    halted    = (state_q == ST_HALT);
    cpu_en    = 1'b0;
    if (nreset) begin
      unique case (state_q)
        ST_RUN, ST_RUN_N: cpu_en = !bp_match;
        ST_STEP:          cpu_en = 1'b1;
        ST_HALT:          cpu_en = 1'b0;
      endcase
    end
  end

  assign halt_reason = reason_q;
  assign bp_hit      = bp_hit_q;
  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;

endmodule
